// File: rtl/mem_stage_dcache_if.sv
// Pipeline-side and backing-memory-side signals of the MEM-stage data cache.
// The slave modport is the cache's view; master is the pipeline/memory view.
interface mem_stage_dcache_if #(
   parameter int DATA_W = 32
);
   logic [31:0]       alu_result_in;
   logic [DATA_W-1:0] read_data_2_in;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] read_data;
   logic              hit;
   logic              mem_req;
   logic              mem_we;
   logic [31:0]       mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  alu_result_in, read_data_2_in, mem_read, mem_write, mem_ack, mem_rdata,
      output read_data, hit, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output alu_result_in, read_data_2_in, mem_read, mem_write, mem_ack, mem_rdata,
      input  read_data, hit, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_stage_dcache.sv
// Direct-mapped, write-through, one-word-per-line MEM-stage data cache.
// Define DCACHE_STATS_EN to add the stat_hits / stat_misses counters.
module mem_stage_dcache #(
   parameter int IDX_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_stage_dcache_if.slave  bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]        stat_hits,
   output logic [31:0]        stat_misses
`endif
);
   localparam int LINES = 1 << IDX_W;
   localparam int TAG_W = 32 - IDX_W - 2;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] resp_q, resp_d;
   logic              store_q, store_d;

   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  line_sel;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES];

   logic [IDX_W-1:0]  in_idx;
   logic [TAG_W-1:0]  in_tag;
   logic [IDX_W-1:0]  inst_idx;
   logic [TAG_W-1:0]  inst_tag;
   logic              line_hit;
   logic              install_en;
   logic [DATA_W-1:0] install_data;
   logic              hit_c;
   logic [DATA_W-1:0] rdata_c;
   logic              count_hit;
   logic              count_miss;
   logic              unused_addr_bits;

   assign in_idx           = bus.alu_result_in[IDX_W+1:2];
   assign in_tag           = bus.alu_result_in[31:IDX_W+2];
   assign inst_idx         = addr_q[IDX_W+1:2];
   assign inst_tag         = addr_q[31:IDX_W+2];
   assign line_hit         = valid_q[in_idx] && (tag_mem[in_idx] == in_tag);
   assign unused_addr_bits = ^{bus.alu_result_in[1:0], count_hit, count_miss};

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_d       = resp_q;
      store_d      = store_q;
      install_en   = 1'b0;
      install_data = wdata_q;
      hit_c        = 1'b1;
      rdata_c      = '0;
      count_hit    = 1'b0;
      count_miss   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // A simultaneous read+write request is handled as a store.
            if (bus.mem_write) begin
               hit_c   = 1'b0;
               state_d = S_WRITE;
               req_d   = 1'b1;
               we_d    = 1'b1;
               addr_d  = {bus.alu_result_in[31:2], 2'b00};
               wdata_d = bus.read_data_2_in;
               store_d = 1'b1;
            end else if (bus.mem_read) begin
               if (line_hit) begin
                  rdata_c   = data_mem[in_idx];
                  count_hit = 1'b1;
               end else begin
                  hit_c      = 1'b0;
                  state_d    = S_FILL;
                  req_d      = 1'b1;
                  we_d       = 1'b0;
                  addr_d     = {bus.alu_result_in[31:2], 2'b00};
                  store_d    = 1'b0;
                  count_miss = 1'b1;
               end
            end
         end
         S_FILL: begin
            hit_c = 1'b0;
            if (bus.mem_ack) begin
               install_en   = 1'b1;
               install_data = bus.mem_rdata;
               resp_d       = bus.mem_rdata;
               req_d        = 1'b0;
               state_d      = S_RESP;
            end
         end
         S_WRITE: begin
            hit_c = 1'b0;
            if (bus.mem_ack) begin
               install_en = 1'b1;
               req_d      = 1'b0;
               we_d       = 1'b0;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            // The pipeline advances on this edge, so always return to IDLE.
            rdata_c = store_q ? '0 : resp_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         resp_q  <= '0;
         store_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         resp_q  <= resp_d;
         store_q <= store_d;
      end
   end

   for (genvar gi = 0; gi < LINES; gi++) begin : g_line_sel
      assign line_sel[gi] = install_en && (inst_idx == IDX_W'(gi));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_q | line_sel;
   end

   // Tag and data arrays carry no reset; valid_q alone qualifies them.
   always_ff @(posedge clk) begin
      if (install_en) begin
         tag_mem[inst_idx]  <= inst_tag;
         data_mem[inst_idx] <= install_data;
      end
   end

   assign bus.hit       = !rst_n || hit_c;
   assign bus.read_data = rst_n ? rdata_c : '0;
   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

`ifdef DCACHE_STATS_EN
   logic [31:0] hits_q, misses_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else begin
         if (count_hit)  hits_q   <= hits_q + 32'd1;
         if (count_miss) misses_q <= misses_q + 32'd1;
      end
   end

   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;
`endif
endmodule

// File: tb/tb_mem_stage_dcache.sv
// Self-checking bench for mem_stage_dcache: directed scenarios plus random
// traffic against a slot-by-word-address reference model.
module tb_mem_stage_dcache;
   localparam int IDX_W = 4;
   localparam int LINES = 1 << IDX_W;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_stage_dcache_if #(.DATA_W(32)) bus();

`ifdef DCACHE_STATS_EN
   logic [31:0] stat_hits, stat_misses;
`endif

   mem_stage_dcache #(.IDX_W(IDX_W), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
`ifdef DCACHE_STATS_EN
      ,
      .stat_hits   (stat_hits),
      .stat_misses (stat_misses)
`endif
   );

   int vectors = 0;
   int errors  = 0;

   // Reference model: each slot remembers which word address it holds.
   logic        m_valid [LINES];
   logic [29:0] m_word  [LINES];
   logic [31:0] m_data  [LINES];
   int          exp_hits, exp_misses;

   typedef struct {
      int          stalls;
      int          req_cycles;
      logic [31:0] rdata;
      logic        saw_req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        stable;
      logic        req_after;
   } obs_t;

   function automatic int slot_of(input logic [31:0] a);
      return int'((a >> 2) % LINES);
   endfunction

   function automatic logic model_hit(input logic [31:0] a);
      int s = slot_of(a);
      return m_valid[s] && (m_word[s] == a[31:2]);
   endfunction

   function automatic void model_install(input logic [31:0] a, input logic [31:0] d);
      int s = slot_of(a);
      m_valid[s] = 1'b1;
      m_word[s]  = a[31:2];
      m_data[s]  = d;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n              = 1'b0;
      bus.mem_read       = 1'b0;
      bus.mem_write      = 1'b0;
      bus.mem_ack        = 1'b0;
      bus.alu_result_in  = '0;
      bus.read_data_2_in = '0;
      bus.mem_rdata      = '0;
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drives one access and plays backing memory, acking k cycles after mem_req rises.
   task automatic drive_access(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input int k, input logic [31:0] fill,
                               output obs_t o);
      @(negedge clk);
      bus.mem_read       = rd;
      bus.mem_write      = wr;
      bus.alu_result_in  = a;
      bus.read_data_2_in = wd;
      bus.mem_ack        = 1'b0;
      #1;
      o = '{default: 0};
      o.stable = 1'b1;
      while (bus.hit !== 1'b1 && o.stalls < 40) begin
         if (bus.mem_req === 1'b1) begin
            if (!o.saw_req) begin
               o.saw_req = 1'b1;
               o.we      = bus.mem_we;
               o.addr    = bus.mem_addr;
               o.wdata   = bus.mem_wdata;
            end else if (bus.mem_we !== o.we || bus.mem_addr !== o.addr || bus.mem_wdata !== o.wdata) begin
               o.stable = 1'b0;
            end
            if (o.req_cycles == k) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = fill;
            end else begin
               bus.mem_rdata = $urandom;
            end
            o.req_cycles++;
         end
         o.stalls++;
         @(negedge clk);
         bus.mem_ack = 1'b0;
         #1;
      end
      o.rdata     = bus.read_data;
      o.req_after = bus.mem_req;
      $display("txn rd=%0b wr=%0b addr=%h k=%0d stalls=%0d rdata=%h req=%0b we=%0b maddr=%h",
               rd, wr, a, k, o.stalls, o.rdata, o.saw_req, o.we, o.addr);
   endtask

   task automatic go_idle();
      @(negedge clk);
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.mem_read  = 1'b1;
      bus.mem_write = 1'b0;
      bus.alu_result_in = 32'h0000_0200;
      @(negedge clk); #1;
      vectors++; if (bus.hit !== 1'b1) begin errors++; $display("FAIL reset_hit: got %b want 1", bus.hit); end
      vectors++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.read_data); end
      vectors++; if ({bus.mem_req, bus.mem_we} !== 2'b00) begin errors++; $display("FAIL reset_req_we: got %b want 00", {bus.mem_req, bus.mem_we}); end
      vectors++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
      apply_reset();
   endtask

   task automatic test_cold_load();
      obs_t o;
      drive_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF, o);
      vectors++; if (o.stalls !== 5) begin errors++; $display("FAIL cold_stalls: got %0d want 5", o.stalls); end
      vectors++; if (o.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cold_rdata: got %h want deadbeef", o.rdata); end
      vectors++; if (o.addr !== 32'h40 || o.we !== 1'b0) begin errors++; $display("FAIL cold_req: got addr %h we %b want 40/0", o.addr, o.we); end
      vectors++; if (o.req_cycles !== 4 || o.req_after !== 1'b0 || !o.stable) begin errors++; $display("FAIL cold_req_len: got %0d cycles after=%b stable=%b want 4/0/1", o.req_cycles, o.req_after, o.stable); end
      drive_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, o);
      vectors++; if (o.stalls !== 0 || o.rdata !== 32'hDEAD_BEEF || o.req_after !== 1'b0) begin errors++; $display("FAIL cold_rehit: got stalls %0d rdata %h req %b want 0/deadbeef/0", o.stalls, o.rdata, o.req_after); end
      go_idle();
`ifdef DCACHE_STATS_EN
      #1;
      vectors++; if (stat_misses !== 32'd1 || stat_hits !== 32'd1) begin errors++; $display("FAIL cold_stats: got hits %0d misses %0d want 1/1", stat_hits, stat_misses); end
`endif
      model_install(32'h40, 32'hDEAD_BEEF);
   endtask

   task automatic test_store_load();
      obs_t o;
      drive_access(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 0, 32'h0, o);
      vectors++; if (o.stalls !== 2 || o.rdata !== 32'h0) begin errors++; $display("FAIL st_stalls: got %0d rdata %h want 2/0", o.stalls, o.rdata); end
      vectors++; if (o.we !== 1'b1 || o.addr !== 32'h80 || o.wdata !== 32'h1234_5678) begin errors++; $display("FAIL st_req: got we %b addr %h data %h want 1/80/12345678", o.we, o.addr, o.wdata); end
      drive_access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 0, 32'h0, o);
      vectors++; if (o.stalls !== 0 || o.rdata !== 32'h1234_5678) begin errors++; $display("FAIL st_load: got stalls %0d rdata %h want 0/12345678", o.stalls, o.rdata); end
      go_idle();
      model_install(32'h80, 32'h1234_5678);
   endtask

   task automatic test_conflict();
      obs_t o;
      logic [31:0] seq [3] = '{32'h0000_0040, 32'h0000_0440, 32'h0000_0040};
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         logic [31:0] f = $urandom;
         drive_access(1'b1, 1'b0, seq[i], 32'h0, i, f, o);
         vectors++; if (o.saw_req !== 1'b1 || o.stalls !== i + 2) begin errors++; $display("FAIL conflict_miss%0d: got req %b stalls %0d want 1/%0d", i, o.saw_req, o.stalls, i + 2); end
         vectors++; if (o.rdata !== f) begin errors++; $display("FAIL conflict_rdata%0d: got %h want %h", i, o.rdata, f); end
         model_install(seq[i], f);
      end
      go_idle();
   endtask

   task automatic test_reset_mid_fill();
      obs_t o;
      int   w = 0;
      apply_reset();
      @(negedge clk);
      bus.mem_read      = 1'b1;
      bus.alu_result_in = 32'h0000_0100;
      #1;
      while (bus.mem_req !== 1'b1 && w < 10) begin @(negedge clk); #1; w++; end
      vectors++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL midfill_req: got %b want 1", bus.mem_req); end
      #1 rst_n = 1'b0;
      #1;
      vectors++; if (bus.mem_req !== 1'b0 || bus.hit !== 1'b1 || bus.read_data !== 32'h0) begin errors++; $display("FAIL midfill_async: got req %b hit %b rdata %h want 0/1/0", bus.mem_req, bus.hit, bus.read_data); end
      @(negedge clk);
      bus.mem_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(negedge clk);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      vectors++; if (bus.mem_req !== 1'b0 || bus.hit !== 1'b1) begin errors++; $display("FAIL midfill_stray: got req %b hit %b want 0/1", bus.mem_req, bus.hit); end
      drive_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'h0000_A5A5, o);
      vectors++; if (o.saw_req !== 1'b1 || o.rdata !== 32'h0000_A5A5) begin errors++; $display("FAIL midfill_reload: got req %b rdata %h want 1/0000a5a5", o.saw_req, o.rdata); end
      go_idle();
      model_install(32'h100, 32'h0000_A5A5);
   endtask

   task automatic test_stray_ack();
      obs_t o;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.mem_read  = 1'b0;
         bus.mem_write = 1'b0;
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = $urandom;
         #1;
         vectors++; if (bus.hit !== 1'b1 || bus.mem_req !== 1'b0 || bus.read_data !== 32'h0) begin errors++; $display("FAIL stray%0d: got hit %b req %b rdata %h want 1/0/0", i, bus.hit, bus.mem_req, bus.read_data); end
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      drive_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h0, o);
      vectors++; if (o.stalls !== 0 || o.rdata !== 32'h0000_A5A5) begin errors++; $display("FAIL stray_keep: got stalls %0d rdata %h want 0/0000a5a5", o.stalls, o.rdata); end
      go_idle();
   endtask

   task automatic test_random();
      obs_t o;
      apply_reset();
      for (int n = 0; n < 200; n++) begin
         int          op   = $urandom_range(0, 3);
         int          k    = $urandom_range(0, 4);
         logic [31:0] a    = (32'($urandom_range(0, 2)) << (IDX_W + 2)) | (32'($urandom_range(0, LINES - 1)) << 2) | 32'($urandom_range(0, 3));
         logic [31:0] wd   = $urandom;
         logic [31:0] fill = $urandom;
         logic        rd   = op[0];
         logic        wr   = op[1];
         int          e_stalls;
         logic [31:0] e_rdata;
         logic        e_req;
         if (wr) begin
            e_stalls = k + 2; e_rdata = 32'h0; e_req = 1'b1;
         end else if (rd && model_hit(a)) begin
            e_stalls = 0; e_rdata = m_data[slot_of(a)]; e_req = 1'b0; exp_hits++;
         end else if (rd) begin
            e_stalls = k + 2; e_rdata = fill; e_req = 1'b1; exp_misses++;
         end else begin
            e_stalls = 0; e_rdata = 32'h0; e_req = 1'b0;
         end
         drive_access(rd, wr, a, wd, k, fill, o);
         vectors++; if (o.stalls !== e_stalls) begin errors++; $display("FAIL rnd_stalls #%0d: got %0d want %0d", n, o.stalls, e_stalls); end
         vectors++; if (o.rdata !== e_rdata) begin errors++; $display("FAIL rnd_rdata #%0d: got %h want %h", n, o.rdata, e_rdata); end
         vectors++; if (o.saw_req !== e_req || o.req_after !== 1'b0) begin errors++; $display("FAIL rnd_req #%0d: got %b after %b want %b/0", n, o.saw_req, o.req_after, e_req); end
         if (e_req) begin
            vectors++;
            if (o.we !== wr || o.addr !== {a[31:2], 2'b00} || (wr && o.wdata !== wd) || !o.stable || o.req_cycles !== k + 1) begin
               errors++;
               $display("FAIL rnd_txn #%0d: got we %b addr %h data %h stable %b len %0d want %b/%h/%h/1/%0d",
                        n, o.we, o.addr, o.wdata, o.stable, o.req_cycles, wr, {a[31:2], 2'b00}, wd, k + 1);
            end
            model_install(a, wr ? wd : fill);
         end
      end
      go_idle();
`ifdef DCACHE_STATS_EN
      #1;
      vectors++; if (stat_hits !== 32'(exp_hits) || stat_misses !== 32'(exp_misses)) begin errors++; $display("FAIL rnd_stats: got %0d/%0d want %0d/%0d", stat_hits, stat_misses, exp_hits, exp_misses); end
`endif
   endtask

   initial begin
      bus.mem_read       = 1'b0;
      bus.mem_write      = 1'b0;
      bus.mem_ack        = 1'b0;
      bus.alu_result_in  = '0;
      bus.read_data_2_in = '0;
      bus.mem_rdata      = '0;
      model_clear();
      test_reset();
      test_cold_load();
      test_store_load();
      test_conflict();
      test_reset_mid_fill();
      test_stray_ack();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
